// File: rtl/ethernet_pkg.sv
// Shared definitions for the ethernet MMIO port arbiter: widths, the
// arbiter state encoding and the response pipeline record.
package ethernet_pkg;

    // MMIO address width of the ethernet controller register port.
    localparam int eth_mmio_addr_width_gp = 14;

    // Operation size field width (byte / half / word / double).
    localparam int eth_mmio_size_width_gp = 2;

    // Largest supported requester count; sizes the response record.
    localparam int eth_mmio_max_req_gp = 8;

    typedef enum logic [0:0] {
        e_arb_idle,
        e_arb_locked
    } eth_arb_state_e;

    // One-cycle response record: which requester issued, and whether the
    // issue was a read (so the controller's sync read data is forwarded).
    typedef struct packed {
        logic [eth_mmio_max_req_gp-1:0] owner_onehot;
        logic                           is_read;
    } eth_mmio_resp_pipe_s;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int eth_rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ethernet_rr_pick.sv
// Combinational round-robin picker: returns the first valid requester at or
// after ptr_i, wrapping from the top index back to 0.
module ethernet_rr_pick #(
    parameter  int num_req_p    = 2,
    localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic [num_req_p-1:0]    v_i,
    input  logic [idx_width_lp-1:0] ptr_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic [idx_width_lp-1:0] idx_o,
    output logic                    v_o
);

    logic [num_req_p-1:0]    at_or_after_ptr;
    logic [num_req_p-1:0]    masked_v;
    logic [num_req_p-1:0]    search_v;
    logic [num_req_p-1:0]    lower_seen;
    logic [idx_width_lp-1:0] idx_terms [num_req_p];
    logic [idx_width_lp-1:0] idx_acc   [num_req_p];

    // Requesters at or above the pointer get first pick; if none of them is
    // valid the search falls back to the whole vector, which is the wrap.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_mask
        assign at_or_after_ptr[gi] = (idx_width_lp'(gi) >= ptr_i);
    end

    assign masked_v = v_i & at_or_after_ptr;
    assign search_v = (|masked_v) ? masked_v : v_i;

    // Lowest set bit of search_v via a prefix "something below is set" chain.
    assign lower_seen[0] = 1'b0;
    for (genvar gi = 1; gi < num_req_p; gi++) begin : g_prefix
        assign lower_seen[gi] = lower_seen[gi-1] | search_v[gi-1];
    end

    assign grant_o = search_v & ~lower_seen;
    assign v_o     = |v_i;

    // Encode the one-hot grant into an index by OR-folding per-bit terms.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_encode
        assign idx_terms[gi] = grant_o[gi] ? idx_width_lp'(gi) : '0;
        if (gi == 0) begin : g_first
            assign idx_acc[gi] = idx_terms[gi];
        end else begin : g_rest
            assign idx_acc[gi] = idx_acc[gi-1] | idx_terms[gi];
        end
    end

    assign idx_o = idx_acc[num_req_p-1];

endmodule

// File: rtl/ethernet_mmio_arbiter.sv
// Round-robin arbiter sharing the ethernet controller's single MMIO register
// port between num_req_p requesters, with optional ownership locking for
// multi-access sequences and a one-cycle synchronous read response path.
// Optional build macro ETH_MMIO_ARB_LOCK_TIMEOUT_EN adds a forced unlock after
// lock_timeout_p idle LOCKED cycles, signalled on lock_timeout_o.
module ethernet_mmio_arbiter
    import ethernet_pkg::*;
#(
    parameter  int num_req_p      = 2,
    parameter  int data_width_p   = 32,
    parameter  int addr_width_p   = eth_mmio_addr_width_gp,
    parameter  int lock_timeout_p = 1024,
    localparam int size_width_lp  = eth_mmio_size_width_gp,
    localparam int idx_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_and_o,
    input  logic [num_req_p-1:0]              req_we_i,
    input  logic [num_req_p-1:0]              req_lock_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*size_width_lp-1:0] req_size_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              resp_v_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic [addr_width_p-1:0]           addr_o,
    output logic                              write_en_o,
    output logic                              read_en_o,
    output logic [size_width_lp-1:0]          op_size_o,
    output logic [data_width_p-1:0]           write_data_o,
    input  logic [data_width_p-1:0]           read_data_i,
`ifdef ETH_MMIO_ARB_LOCK_TIMEOUT_EN
    output logic                              lock_timeout_o,
`endif
    output logic [idx_width_lp-1:0]           owner_o
);

    eth_arb_state_e          state_r;
    logic [idx_width_lp-1:0] ptr_r;
    logic [idx_width_lp-1:0] owner_r;
    eth_mmio_resp_pipe_s     resp_r;

    logic [num_req_p-1:0]    pick_grant;
    logic [idx_width_lp-1:0] pick_idx;
    logic                    pick_v;

    logic [num_req_p-1:0]    grant_v;
    logic [idx_width_lp-1:0] grant_idx;
    logic                    issue;
    logic                    timeout_fire;

    logic [addr_width_p-1:0]  addr_arr [num_req_p];
    logic [size_width_lp-1:0] size_arr [num_req_p];
    logic [data_width_p-1:0]  data_arr [num_req_p];

    // Unpack the per-requester command fields.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr_i[gi*addr_width_p +: addr_width_p];
        assign size_arr[gi] = req_size_i[gi*size_width_lp +: size_width_lp];
        assign data_arr[gi] = req_data_i[gi*data_width_p +: data_width_p];
    end

    ethernet_rr_pick #(
        .num_req_p (num_req_p)
    ) u_pick (
        .v_i     (req_v_i),
        .ptr_i   (ptr_r),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .v_o     (pick_v)
    );

    // Grant selection: round-robin when idle, owner-only when locked. With no
    // grant the select index parks on the last owner so the command mux holds
    // that requester's fields. Reset forces every grant low.
    always_comb begin
        grant_v   = '0;
        grant_idx = owner_r;
        issue     = 1'b0;
        if (reset_n_i) begin
            if (state_r == e_arb_locked) begin
                if (req_v_i[owner_r]) begin
                    grant_v[owner_r] = 1'b1;
                    issue            = 1'b1;
                end
            end else if (pick_v) begin
                grant_v   = pick_grant;
                grant_idx = pick_idx;
                issue     = 1'b1;
            end
        end
    end

    assign req_ready_and_o = grant_v;
    assign write_en_o      = issue &  req_we_i[grant_idx];
    assign read_en_o       = issue & ~req_we_i[grant_idx];
    assign addr_o          = reset_n_i ? addr_arr[grant_idx] : '0;
    assign op_size_o       = reset_n_i ? size_arr[grant_idx] : '0;
    assign write_data_o    = reset_n_i ? data_arr[grant_idx] : '0;
    assign owner_o         = owner_r;

    // Read data is forwarded only while a read response is in flight.
    assign resp_v_o    = resp_r.owner_onehot[num_req_p-1:0];
    assign resp_data_o = (resp_r.is_read && (|resp_r.owner_onehot)) ? read_data_i : '0;

`ifdef ETH_MMIO_ARB_LOCK_TIMEOUT_EN
    localparam int cnt_width_lp = $clog2(lock_timeout_p + 1);

    logic [cnt_width_lp-1:0] idle_cnt_r;

    // Fires on the lock_timeout_p-th consecutive locked cycle without an owner issue.
    assign timeout_fire   = (state_r == e_arb_locked) && !issue &&
                            (idle_cnt_r == cnt_width_lp'(lock_timeout_p - 1));
    assign lock_timeout_o = timeout_fire;

    // Count consecutive idle locked cycles; any owner issue or unlock restarts it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_cnt_r <= '0;
        end else if ((state_r != e_arb_locked) || issue || timeout_fire) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // Arbiter FSM, round-robin pointer, owner tracking and response pipe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_arb_idle;
            ptr_r   <= '0;
            owner_r <= '0;
            resp_r  <= '0;
        end else begin
            resp_r.owner_onehot <= eth_mmio_max_req_gp'(grant_v);
            resp_r.is_read      <= issue & ~req_we_i[grant_idx];
            if (issue) begin
                owner_r <= grant_idx;
                ptr_r   <= idx_width_lp'(eth_rr_wrap_inc(int'(grant_idx), num_req_p));
                state_r <= req_lock_i[grant_idx] ? e_arb_locked : e_arb_idle;
            end else if (timeout_fire) begin
                ptr_r   <= idx_width_lp'(eth_rr_wrap_inc(int'(owner_r), num_req_p));
                state_r <= e_arb_idle;
            end
        end
    end

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Self-checking bench for ethernet_mmio_arbiter: directed scenarios followed
// by randomized traffic, all checked against a behavioural arbitration model.
module tb_ethernet_mmio_arbiter;

    localparam int N  = 2;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    v, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*SW-1:0] size;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata;

    logic [N-1:0]    ready, resp_v;
    logic [DW-1:0]   resp_data, wdata_o;
    logic [AW-1:0]   addr_o;
    logic            we_o, re_o;
    logic [SW-1:0]   size_o;
    logic            owner;

    always #5 clk = ~clk;

    ethernet_mmio_arbiter dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_v_i         (v),
        .req_ready_and_o (ready),
        .req_we_i        (we),
        .req_lock_i      (lock),
        .req_addr_i      (addr),
        .req_size_i      (size),
        .req_data_i      (wdata),
        .resp_v_o        (resp_v),
        .resp_data_o     (resp_data),
        .addr_o          (addr_o),
        .write_en_o      (we_o),
        .read_en_o       (re_o),
        .op_size_o       (size_o),
        .write_data_o    (wdata_o),
        .read_data_i     (rdata),
        .owner_o         (owner)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: who owns the lock, where round-robin resumes, who was
    // last granted, and what response is due this cycle.
    int m_ptr, m_locked, m_owner, m_last, m_pend, m_pend_rd;
    int last_g;

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0; m_last = 0; m_pend = 0; m_pend_rd = 0;
    endtask

    task automatic clear_inputs();
        v = '0; we = '0; lock = '0; addr = '0; size = '0; wdata = '0; rdata = '0;
    endtask

    task automatic set_req(input int i, input bit vv, input bit w, input bit l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        v[i] = vv; we[i] = w; lock[i] = l;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
        size[i*SW +: SW] = SW'($urandom_range(0, 3));
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ready"}, ready, 0);
        chk({pfx, "_resp_v"}, resp_v, 0);
        chk({pfx, "_resp_data"}, resp_data, 0);
        chk({pfx, "_addr"}, addr_o, 0);
        chk({pfx, "_we"}, we_o, 0);
        chk({pfx, "_re"}, re_o, 0);
        chk({pfx, "_size"}, size_o, 0);
        chk({pfx, "_wdata"}, wdata_o, 0);
        chk({pfx, "_owner"}, owner, 0);
    endtask

    // One cycle: called just after a rising edge with inputs set; checks the
    // combinational outputs against the model, then advances the model.
    task automatic step();
        int g, sel, c;
        rdata = $urandom();
        g = -1;
        if (m_locked != 0) begin
            if (v[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        sel = (g >= 0) ? g : m_last;
        #2;
        chk("ready", ready, (g >= 0) ? (1 << g) : 0);
        chk("write_en", we_o, (g >= 0) ? we[sel] : 1'b0);
        chk("read_en", re_o, (g >= 0) ? !we[sel] : 1'b0);
        chk("addr", addr_o, addr[sel*AW +: AW]);
        chk("size", size_o, size[sel*SW +: SW]);
        chk("wdata", wdata_o, wdata[sel*DW +: DW]);
        chk("owner", owner, m_last);
        chk("resp_v", resp_v, m_pend);
        chk("resp_data", resp_data, (m_pend_rd != 0) ? rdata : '0);
        last_g = g;
        $display("cyc t=%0t v=%b grant=%0d resp_v=%b", $time, v, g, resp_v);
        @(posedge clk);
        m_pend    = (g >= 0) ? (1 << g) : 0;
        m_pend_rd = (g >= 0 && !we[sel]) ? 1 : 0;
        if (g >= 0) begin
            m_last   = g;
            m_ptr    = (g + 1) % N;
            m_locked = lock[g] ? 1 : 0;
            m_owner  = g;
        end
        #1;
    endtask

    initial begin
        int cnt0, cnt1, prev;
        clear_inputs();
        model_reset();
        reset_n = 1'b0;
        // Busy inputs during reset must not leak onto any output.
        set_req(0, 1, 0, 1, 14'h1abc, 32'h12345678);
        set_req(1, 1, 1, 0, 14'h0f0f, 32'hcafef00d);
        #2;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_inputs();
        step();

        // Single read from requester 0, response one cycle later.
        set_req(0, 1, 0, 0, 14'h0010, 32'h0);
        step();
        chk("single_read_grant", last_g, 0);
        clear_inputs();
        step();

        // Fairness: both requesters valid, no lock, for 8 cycles.
        cnt0 = 0; cnt1 = 0; prev = 0;
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1, $urandom_range(0, 1), 0, AW'($urandom()), $urandom());
            set_req(1, 1, $urandom_range(0, 1), 0, AW'($urandom()), $urandom());
            step();
            if (last_g == 0) cnt0++;
            if (last_g == 1) cnt1++;
            if (i > 0) chk("fair_alternate", (last_g != prev), 1);
            prev = last_g;
        end
        chk("fair_cnt0", cnt0, 4);
        chk("fair_cnt1", cnt1, 4);

        // Lock: requester 1 holds the port for 3 locked writes and 1 release.
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 0, 0, 14'h0020, 32'h0);
            set_req(1, 1, 1, (i < 3), AW'(14'h0100 + i), $urandom());
            step();
            chk("lock_grant", last_g, 1);
        end
        set_req(1, 0, 0, 0, 14'h0, 32'h0);
        step();
        chk("lock_release_grant", last_g, 0);

        // Write response carries zero data.
        clear_inputs();
        set_req(0, 1, 1, 0, 14'h0044, 32'hDEADBEEF);
        step();
        chk("write_grant", last_g, 0);
        clear_inputs();
        step();

        // Reset while locked with a read response pending.
        set_req(0, 1, 0, 1, 14'h0030, 32'h0);
        step();
        clear_inputs();
        v = 2'b11;
        rdata = 32'hA5A5A5A5;
        #1;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        clear_inputs();
        set_req(1, 1, 0, 0, 14'h0055, 32'h0);
        step();
        chk("post_reset_grant", last_g, 1);
        clear_inputs();
        step();

        // Randomized traffic with occasional locks.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) begin
                set_req(r, $urandom_range(0, 1), $urandom_range(0, 1),
                        ($urandom_range(0, 3) == 0), AW'($urandom()), $urandom());
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
